// File: rtl/univ_shift_reg.sv
// Universal shift register: single-cycle load/shift/rotate/clear ops plus a
// counted multi-cycle burst shift. Optional parity output under USR_PARITY_EN.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  input  logic             start,
  input  logic [CNT_W-1:0] amt,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
`ifdef USR_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_LOAD  = 3'b001;
  localparam logic [2:0] M_SHL   = 3'b010;
  localparam logic [2:0] M_SHR   = 3'b011;
  localparam logic [2:0] M_ROTL  = 3'b100;
  localparam logic [2:0] M_ROTR  = 3'b101;
  localparam logic [2:0] M_CLEAR = 3'b110;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       lmode, lmode_n;
  logic [WIDTH-1:0] q_n;
  logic             done_n;
  logic [2:0]       eff_mode;
  logic             shift_mode;

  function automatic logic [WIDTH-1:0] apply_op(input logic [2:0] m,
                                                 input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] ld,
                                                 input logic si);
    case (m)
      M_LOAD:  apply_op = ld;
      M_SHL:   apply_op = {cur[WIDTH-2:0], si};
      M_SHR:   apply_op = {si, cur[WIDTH-1:1]};
      M_ROTL:  apply_op = {cur[WIDTH-2:0], cur[WIDTH-1]};
      M_ROTR:  apply_op = {cur[0], cur[WIDTH-1:1]};
      M_CLEAR: apply_op = '0;
      default: apply_op = cur;
    endcase
  endfunction

  assign shift_mode = (mode == M_SHL) || (mode == M_SHR) ||
                      (mode == M_ROTL) || (mode == M_ROTR);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    lmode_n = lmode;
    q_n     = q;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          // A degenerate burst still pulses done so requesters never stall.
          if (amt != '0 && shift_mode) begin
            state_n = BUSY;
            cnt_n   = amt;
            lmode_n = mode;
          end else begin
            done_n = 1'b1;
          end
        end else if (en) begin
          q_n = apply_op(mode, q, d, sin);
        end
      end
      BUSY: begin
        q_n   = apply_op(lmode, q, d, sin);
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      lmode <= M_HOLD;
      q     <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      lmode <= lmode_n;
      q     <= q_n;
      done  <= done_n;
    end
  end

  assign busy     = (state == BUSY);
  assign eff_mode = busy ? lmode : mode;
  assign sout     = (eff_mode == M_SHL || eff_mode == M_ROTL) ? q[WIDTH-1] : q[0];

`ifdef USR_PARITY_EN
  assign parity = ^q;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8); parity checks run only when
// USR_PARITY_EN is defined.
module tb_univ_shift_reg;
  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [2:0]    mode;
  logic [W-1:0]  d;
  logic          sin;
  logic          start;
  logic [CW-1:0] amt;
  logic [W-1:0]  q;
  logic          sout, busy, done;
`ifdef USR_PARITY_EN
  logic          parity;
`endif

  int checks = 0;
  int errors = 0;

  univ_shift_reg #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d), .sin(sin),
    .start(start), .amt(amt), .q(q), .sout(sout), .busy(busy), .done(done)
`ifdef USR_PARITY_EN
    , .parity(parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b0; mode = 3'b000; d = '0; sin = 1'b0; start = 1'b0; amt = '0;
  endtask

  task automatic load(input logic [W-1:0] v);
    en = 1'b1; mode = 3'b001; d = v;
    tick();
    en = 1'b0; mode = 3'b000;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    checks++;
    if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: q=%h busy=%b done=%b, want 00 0 0", q, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ops();
    load(8'hA5);
    checks++;
    if (q !== 8'hA5) begin errors++; $display("FAIL load: q=%h want a5", q); end
    en = 1'b1; mode = 3'b100;
    #1;
    checks++;
    if (sout !== 1'b1) begin errors++; $display("FAIL sout_rotl: got %b want 1", sout); end
    tick();
    checks++;
    if (q !== 8'h4B) begin errors++; $display("FAIL rotl: q=%h want 4b", q); end
    mode = 3'b101; tick();
    checks++;
    if (q !== 8'hA5) begin errors++; $display("FAIL rotr: q=%h want a5", q); end
    mode = 3'b010; sin = 1'b0; tick();
    checks++;
    if (q !== 8'h4A) begin errors++; $display("FAIL shl: q=%h want 4a", q); end
    mode = 3'b011; sin = 1'b1; #1;
    checks++;
    if (sout !== 1'b0) begin errors++; $display("FAIL sout_shr: got %b want 0", sout); end
    tick();
    checks++;
    if (q !== 8'hA5) begin errors++; $display("FAIL shr: q=%h want a5", q); end
    mode = 3'b111; tick();
    checks++;
    if (q !== 8'hA5) begin errors++; $display("FAIL hold111: q=%h want a5", q); end
    mode = 3'b110; tick();
    checks++;
    if (q !== 8'h00) begin errors++; $display("FAIL clear: q=%h want 00", q); end
    en = 1'b0; mode = 3'b001; d = 8'hFF; tick();
    checks++;
    if (q !== 8'h00) begin errors++; $display("FAIL en_low: q=%h want 00", q); end
    idle_inputs();
  endtask

  task automatic test_burst_shl();
    int nb;
    logic s1;
    load(8'h81);
    mode = 3'b010; start = 1'b1; amt = 4'd3; sin = 1'b1;
    tick();
    start = 1'b0; mode = 3'b000; en = 1'b1; d = 8'h55;
    checks++;
    if (q !== 8'h81) begin errors++; $display("FAIL shl_start_edge: q=%h want 81", q); end
    nb = 0; s1 = 1'bx;
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      nb++;
      if (i == 1) s1 = sout;
      tick();
    end
    checks++;
    if (nb != 3) begin errors++; $display("FAIL shl_busy_len: got %0d want 3", nb); end
    checks++;
    if (s1 !== 1'b0) begin errors++; $display("FAIL shl_sout_latched: got %b want 0", s1); end
    checks++;
    if (q !== 8'h0F || done !== 1'b1) begin
      errors++; $display("FAIL shl_result: q=%h done=%b want 0f 1", q, done);
    end
    idle_inputs();
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL shl_done_width: done=%b want 0", done); end
  endtask

  task automatic test_burst_rotr();
    int nb;
    load(8'h01);
    mode = 3'b101; start = 1'b1; amt = 4'd9;
    tick();
    start = 1'b0; mode = 3'b000;
    nb = 0;
    for (int i = 0; i < 30; i++) begin
      if (!busy) break;
      nb++;
      if (i == 4) begin start = 1'b1; amt = 4'd2; mode = 3'b010; end
      else begin start = 1'b0; mode = 3'b000; end
      tick();
    end
    idle_inputs();
    checks++;
    if (nb != 9) begin errors++; $display("FAIL rotr_busy_len: got %0d want 9", nb); end
    checks++;
    if (q !== 8'h80 || done !== 1'b1) begin
      errors++; $display("FAIL rotr_result: q=%h done=%b want 80 1", q, done);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rotr_no_restart: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_degenerate_start();
    mode = 3'b010; start = 1'b1; amt = 4'd0;
    tick();
    start = 1'b0;
    checks++;
    if (q !== 8'h80 || busy !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL amt0: q=%h busy=%b done=%b want 80 0 1", q, busy, done);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL amt0_done_width: done=%b want 0", done); end
    // non-shift mode with start wins over en: no load happens
    en = 1'b1; mode = 3'b001; d = 8'h00; start = 1'b1; amt = 4'd3;
    tick();
    idle_inputs();
    checks++;
    if (q !== 8'h80 || busy !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL nonshift_start: q=%h busy=%b done=%b want 80 0 1", q, busy, done);
    end
  endtask

  task automatic test_back_to_back();
    load(8'h0F);
    mode = 3'b100; start = 1'b1; amt = 4'd2;
    tick();
    start = 1'b0;
    tick(); tick();
    checks++;
    if (q !== 8'h3C || done !== 1'b1) begin
      errors++; $display("FAIL b2b_first: q=%h done=%b want 3c 1", q, done);
    end
    mode = 3'b011; sin = 1'b0; start = 1'b1; amt = 4'd1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_second_busy: busy=%b done=%b want 1 0", busy, done);
    end
    tick();
    checks++;
    if (q !== 8'h1E || done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_second: q=%h done=%b busy=%b want 1e 1 0", q, done, busy);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_burst();
    int seen;
    load(8'hFF);
    mode = 3'b010; sin = 1'b1; start = 1'b1; amt = 4'd5;
    tick();
    start = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL async_reset: q=%h busy=%b done=%b want 00 0 0", q, busy, done);
    end
    #1 rst_n = 1'b1;
    idle_inputs();
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done || busy) seen++;
    end
    checks++;
    if (seen != 0 || q !== 8'h00) begin
      errors++; $display("FAIL reset_abort: activity=%0d q=%h want 0 00", seen, q);
    end
  endtask

`ifdef USR_PARITY_EN
  task automatic test_parity();
    load(8'h07);
    checks++;
    if (parity !== 1'b1) begin errors++; $display("FAIL parity_07: got %b want 1", parity); end
    load(8'h03);
    checks++;
    if (parity !== 1'b0) begin errors++; $display("FAIL parity_03: got %b want 0", parity); end
  endtask
`endif

  initial begin
    test_reset();
    test_ops();
    test_burst_shl();
    test_burst_rotr();
    test_degenerate_start();
    test_back_to_back();
    test_reset_mid_burst();
`ifdef USR_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, want finish before 50000");
    $fatal(1);
  end
endmodule
